mc_controller: RTL and testbench

- Main control FSM for the multicycle RV32I core.
- Sequences the shared ALU, instruction register, PC, register file and the unified instruction/data memory port across cycles.
- Drives `aluop` into the ALU decoder, which resolves the final 4-bit ALU control from `aluop`, `opcode`, `func3` and `func7`.
- Adds a `mem_ready` wait handshake and a retired-instruction counter.

---
 rtl/mc_ctrl_pkg.sv | 49 ++++
 rtl/mc_ctrl_outdec.sv | 111 +++++++++++
 rtl/mc_controller.sv | 96 +++++++++
 tb/tb_mc_controller.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: states, opcodes and
// datapath select codes used by the controller and its output decoder.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_AUIPC    = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_B_TYPE = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_DECODE = 2'b10;

  // True when leaving this state back to FETCH completes an instruction.
  function automatic logic retiring_state(state_t s);
    return (s == S_MEMWB) || (s == S_MEMWRITE) || (s == S_ALUWB) || (s == S_BEQ);
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state-to-control decoder for the multicycle core, including
// the mem_ready/zero gated enables and the write-enable kill during reset.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       reset,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop
);

  logic pc_write_raw;
  logic ir_write_raw;
  logic mem_write_raw;
  logic reg_write_raw;

  always_comb begin
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    adr_src       = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    aluop         = 2'b00;
    case (state)
      S_FETCH: begin
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_FOUR;
        aluop        = ALUOP_ADD;
        result_src   = RES_ALURESULT;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        aluop     = ALUOP_ADD;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        aluop     = ALUOP_ADD;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        result_src    = RES_MEMDATA;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        result_src    = RES_ALUOUT;
        mem_write_raw = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        aluop     = ALUOP_DECODE;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        aluop     = ALUOP_DECODE;
      end
      S_AUIPC: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        aluop     = ALUOP_DECODE;
      end
      S_ALUWB: begin
        result_src    = RES_ALUOUT;
        reg_write_raw = 1'b1;
      end
      S_JAL: begin
        alu_src_a    = SRCA_OLDPC;
        alu_src_b    = SRCB_FOUR;
        aluop        = ALUOP_ADD;
        result_src   = RES_ALUOUT;
        pc_write_raw = 1'b1;
      end
      S_BEQ: begin
        // ALU decoder turns ALUOP_DECODE into subtract for branch opcodes.
        alu_src_a    = SRCA_RS1;
        alu_src_b    = SRCB_RS2;
        aluop        = ALUOP_DECODE;
        result_src   = RES_ALUOUT;
        pc_write_raw = zero;
      end
      default: ;
    endcase
  end

  assign pc_write  = pc_write_raw  & ~reset;
  assign ir_write  = ir_write_raw  & ~reset;
  assign mem_write = mem_write_raw & ~reset;
  assign reg_write = reg_write_raw & ~reset;

endmodule

// File: rtl/mc_controller.sv
// Main control FSM of the multicycle RV32I core: state register, next-state
// logic, sticky illegal-instruction flag and retired-instruction counter.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       aluop,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  state_t             state_q, state_d;
  logic               illegal_q;
  logic [CNT_W-1:0]   instret_q;
  logic               retire;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R_TYPE:         state_d = S_EXECR;
          OP_I_TYPE:         state_d = S_EXECI;
          OP_B_TYPE:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_AUIPC:    state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
  end

  assign retire = retiring_state(state_q) && (state_d == S_FETCH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP) illegal_q <= 1'b1;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  mc_ctrl_outdec u_outdec (
    .state      (state_q),
    .reset      (reset),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .aluop      (aluop)
  );

  assign state   = state_q;
  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-cycle expectations are queued as
// stimulus is driven and compared against the DUT half a cycle later.
module tb_mc_controller;
  import mc_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_write;
  logic        ir_write;
  logic        adr_src;
  logic        mem_write;
  logic        reg_write;
  logic [1:0]  result_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  aluop;
  logic        illegal;
  logic [3:0]  state;
  logic [31:0] instret;

  typedef struct packed {
    logic [3:0]  st;
    logic        pcw;
    logic        irw;
    logic        adr;
    logic        mw;
    logic        rw;
    logic [1:0]  res;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [1:0]  op;
    logic        ill;
    logic [31:0] cnt;
  } exp_t;

  exp_t        expQueue[$];
  int          checkCount;
  int          errCount;
  int          cycleNum;
  logic [31:0] expInstret;

  mc_controller #(.CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .aluop      (aluop),
    .illegal    (illegal),
    .state      (state),
    .instret    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference control table written straight from the state descriptions.
  function automatic exp_t modelOut(input logic [3:0] s, input logic mr, input logic z,
                                    input logic rst, input logic [31:0] cnt);
    exp_t e;
    e = '0;
    e.st  = s;
    e.cnt = cnt;
    case (s)
      4'd0:  begin e.sb = 2'b10; e.res = 2'b10; e.irw = mr; e.pcw = mr; end
      4'd1:  begin e.sa = 2'b01; e.sb = 2'b01; end
      4'd2:  begin e.sa = 2'b10; e.sb = 2'b01; end
      4'd3:  begin e.adr = 1'b1; end
      4'd4:  begin e.res = 2'b01; e.rw = 1'b1; end
      4'd5:  begin e.adr = 1'b1; e.mw = 1'b1; end
      4'd6:  begin e.sa = 2'b10; e.sb = 2'b00; e.op = 2'b10; end
      4'd7:  begin e.rw = 1'b1; end
      4'd8:  begin e.sa = 2'b10; e.sb = 2'b01; e.op = 2'b10; end
      4'd9:  begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
      4'd10: begin e.sa = 2'b10; e.op = 2'b10; e.pcw = z; end
      4'd11: begin e.sa = 2'b01; e.sb = 2'b01; e.op = 2'b10; end
      4'd12: begin e.ill = 1'b1; end
      default: ;
    endcase
    if (rst) begin
      e.pcw = 1'b0;
      e.irw = 1'b0;
      e.mw  = 1'b0;
      e.rw  = 1'b0;
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL c%0d %s actual=%0h expected=%0h", cycleNum, tag, actual, expected);
    end
  endtask

  // One clock: drive inputs after the edge, queue the expectation, compare mid-cycle.
  task automatic applyStimulus(input logic [3:0] expState, input logic mr, input logic z,
                               input logic rst, input logic [6:0] op);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    mem_ready = mr;
    zero      = z;
    opcode    = op;
    expQueue.push_back(modelOut(expState, mr, z, rst, expInstret));
    #4;
    e = expQueue.pop_front();
    checkOutput("state",      32'(state),      32'(e.st));
    checkOutput("pc_write",   32'(pc_write),   32'(e.pcw));
    checkOutput("ir_write",   32'(ir_write),   32'(e.irw));
    checkOutput("adr_src",    32'(adr_src),    32'(e.adr));
    checkOutput("mem_write",  32'(mem_write),  32'(e.mw));
    checkOutput("reg_write",  32'(reg_write),  32'(e.rw));
    checkOutput("result_src", 32'(result_src), 32'(e.res));
    checkOutput("alu_src_a",  32'(alu_src_a),  32'(e.sa));
    checkOutput("alu_src_b",  32'(alu_src_b),  32'(e.sb));
    checkOutput("aluop",      32'(aluop),      32'(e.op));
    checkOutput("illegal",    32'(illegal),    32'(e.ill));
    checkOutput("instret",    instret,         e.cnt);
    if (rst)
      expInstret = 32'd0;
    else if (expState == 4'd4 || expState == 4'd7 || expState == 4'd10 ||
             (expState == 4'd5 && mr))
      expInstret = expInstret + 32'd1;
    cycleNum++;
  endtask

  initial begin
    checkCount = 0;
    errCount   = 0;
    cycleNum   = 0;
    expInstret = 32'd0;
    reset      = 1'b1;
    mem_ready  = 1'b1;
    zero       = 1'b0;
    opcode     = 7'b0;
    @(posedge clk);

    // Reset held: FETCH with all write enables killed.
    applyStimulus(S_FETCH, 1'b1, 1'b0, 1'b1, OP_LOAD);

    // lw with two MEMREAD wait states.
    applyStimulus(S_FETCH,   1'b1, 1'b0, 1'b0, OP_LOAD);
    applyStimulus(S_DECODE,  1'b1, 1'b0, 1'b0, OP_LOAD);
    applyStimulus(S_MEMADR,  1'b1, 1'b0, 1'b0, OP_LOAD);
    applyStimulus(S_MEMREAD, 1'b0, 1'b0, 1'b0, OP_LOAD);
    applyStimulus(S_MEMREAD, 1'b0, 1'b0, 1'b0, OP_LOAD);
    applyStimulus(S_MEMREAD, 1'b1, 1'b0, 1'b0, OP_LOAD);
    applyStimulus(S_MEMWB,   1'b1, 1'b0, 1'b0, OP_LOAD);

    // sw with zero wait states.
    applyStimulus(S_FETCH,    1'b1, 1'b0, 1'b0, OP_STORE);
    applyStimulus(S_DECODE,   1'b1, 1'b0, 1'b0, OP_STORE);
    applyStimulus(S_MEMADR,   1'b1, 1'b0, 1'b0, OP_STORE);
    applyStimulus(S_MEMWRITE, 1'b1, 1'b0, 1'b0, OP_STORE);

    // beq taken, then beq not taken.
    applyStimulus(S_FETCH,  1'b1, 1'b0, 1'b0, OP_B_TYPE);
    applyStimulus(S_DECODE, 1'b1, 1'b0, 1'b0, OP_B_TYPE);
    applyStimulus(S_BEQ,    1'b1, 1'b1, 1'b0, OP_B_TYPE);
    applyStimulus(S_FETCH,  1'b1, 1'b0, 1'b0, OP_B_TYPE);
    applyStimulus(S_DECODE, 1'b1, 1'b0, 1'b0, OP_B_TYPE);
    applyStimulus(S_BEQ,    1'b1, 1'b0, 1'b0, OP_B_TYPE);

    // add, then addi after a stalled fetch.
    applyStimulus(S_FETCH,  1'b1, 1'b0, 1'b0, OP_R_TYPE);
    applyStimulus(S_DECODE, 1'b1, 1'b0, 1'b0, OP_R_TYPE);
    applyStimulus(S_EXECR,  1'b1, 1'b0, 1'b0, OP_R_TYPE);
    applyStimulus(S_ALUWB,  1'b1, 1'b0, 1'b0, OP_R_TYPE);
    applyStimulus(S_FETCH,  1'b0, 1'b0, 1'b0, OP_I_TYPE);
    applyStimulus(S_FETCH,  1'b1, 1'b0, 1'b0, OP_I_TYPE);
    applyStimulus(S_DECODE, 1'b1, 1'b0, 1'b0, OP_I_TYPE);
    applyStimulus(S_EXECI,  1'b1, 1'b0, 1'b0, OP_I_TYPE);
    applyStimulus(S_ALUWB,  1'b1, 1'b0, 1'b0, OP_I_TYPE);

    // auipc and jal.
    applyStimulus(S_FETCH,  1'b1, 1'b0, 1'b0, OP_AUIPC);
    applyStimulus(S_DECODE, 1'b1, 1'b0, 1'b0, OP_AUIPC);
    applyStimulus(S_AUIPC,  1'b1, 1'b0, 1'b0, OP_AUIPC);
    applyStimulus(S_ALUWB,  1'b1, 1'b0, 1'b0, OP_AUIPC);
    applyStimulus(S_FETCH,  1'b1, 1'b0, 1'b0, OP_JAL);
    applyStimulus(S_DECODE, 1'b1, 1'b0, 1'b0, OP_JAL);
    applyStimulus(S_JAL,    1'b1, 1'b0, 1'b0, OP_JAL);
    applyStimulus(S_ALUWB,  1'b1, 1'b0, 1'b0, OP_JAL);

    // Store aborted by reset while waiting on memory.
    applyStimulus(S_FETCH,    1'b1, 1'b0, 1'b0, OP_STORE);
    applyStimulus(S_DECODE,   1'b1, 1'b0, 1'b0, OP_STORE);
    applyStimulus(S_MEMADR,   1'b1, 1'b0, 1'b0, OP_STORE);
    applyStimulus(S_MEMWRITE, 1'b0, 1'b0, 1'b0, OP_STORE);
    applyStimulus(S_MEMWRITE, 1'b0, 1'b0, 1'b1, OP_STORE);
    applyStimulus(S_FETCH,    1'b0, 1'b0, 1'b0, OP_STORE);

    // Illegal opcode: trap, sit there, then leave via reset.
    applyStimulus(S_FETCH,  1'b1, 1'b0, 1'b0, 7'b1111111);
    applyStimulus(S_DECODE, 1'b1, 1'b0, 1'b0, 7'b1111111);
    for (int i = 0; i < 10; i++)
      applyStimulus(S_TRAP, 1'b1, 1'b1, 1'b0, 7'b1111111);
    applyStimulus(S_TRAP,  1'b1, 1'b0, 1'b1, 7'b1111111);
    applyStimulus(S_FETCH, 1'b1, 1'b0, 1'b0, OP_R_TYPE);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
